// File: rtl/project_ram_pkg.sv
// project_ram_pkg: shared types and constants for the project_ram block.
//   state_t   - sequencer states (IDLE, LOAD, RELEASE, RUN)
//   WORD_W    - memory word width
//   depth_of  - number of words for a given address width
package project_ram_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    function automatic int depth_of(input int size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/project_ram_if.sv
// project_ram_if: CPU memory bus plus streaming loader port.
//   CPU side : addr_toRAM, data_toRAM, wrEn  -> RAM ; data_fromRAM <- RAM
//   Loader   : ld_valid, ld_data, ld_last    -> RAM ; ld_ready     <- RAM
// master = CPU/loader end, slave = RAM end.
interface project_ram_if
    import project_ram_pkg::*;
#(
    parameter int SIZE = 10
);
    logic [SIZE-1:0]   addr_toRAM;
    logic [WORD_W-1:0] data_toRAM;
    logic              wrEn;
    logic [WORD_W-1:0] data_fromRAM;
    logic              ld_valid;
    logic [WORD_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    modport master (
        output addr_toRAM, data_toRAM, wrEn, ld_valid, ld_data, ld_last,
        input  data_fromRAM, ld_ready
    );

    modport slave (
        input  addr_toRAM, data_toRAM, wrEn, ld_valid, ld_data, ld_last,
        output data_fromRAM, ld_ready
    );
endinterface

// File: rtl/project_ram_array.sv
// ram_array: DEPTH x WORD_W storage, one write port, one synchronous
// read-first read port.
//   clk, rst  - clock, synchronous active-high reset (read register only)
//   we_i, waddr_i, wdata_i - write port
//   re_i, raddr_i          - read enable / address; re_i=0 loads 0
//   rdata_o                - registered read data
module ram_array
    import project_ram_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [SIZE-1:0]   waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [SIZE-1:0]   raddr_i,
    output logic [WORD_W-1:0] rdata_o
);
    localparam int DEPTH = depth_of(SIZE);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage is deliberately not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read alongside the write gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/project_ram.sv
// project_ram: word-addressed RAM serving the CPU memory port, with a
// streaming program loader that holds the CPU in reset until loading ends.
//   clk, rst     - clock, synchronous active-high reset
//   bus          - project_ram_if.slave (CPU bus + loader handshake)
//   reload       - single-cycle request from RUN back to LOAD
//   cpu_rst      - reset to the CPU, low only in RUN
//   wr_count     - saturating count of accepted CPU writes
//   wr_violation - sticky protected-write flag
// Optional build macro RAM_WR_PROTECT_EN: CPU writes below PROT_LIMIT are
// dropped, not counted, and set wr_violation. Without it wr_violation is 0.
//
// state   | meaning
// IDLE    | one cycle after reset
// LOAD    | loader owns the write port, ld_ready=1
// RELEASE | one cycle gap, CPU still in reset
// RUN     | CPU owns the RAM, cpu_rst=0
module project_ram
    import project_ram_pkg::*;
#(
    parameter int SIZE       = 10,
    parameter int PROT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    project_ram_if.slave      bus,
    input  logic              reload,
    output logic              cpu_rst,
    output logic [WORD_W-1:0] wr_count,
    output logic              wr_violation
);
    localparam int              DEPTH     = depth_of(SIZE);
    localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [SIZE-1:0]   ld_ptr_q, ld_ptr_d;
    logic [WORD_W-1:0] wr_count_q, wr_count_d;
    logic              cpu_wr_ok;
    logic              ram_we;
    logic [SIZE-1:0]   ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_ptr_q   <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_ptr_d     = ld_ptr_q;
        wr_count_d   = wr_count_q;
        ram_we       = 1'b0;
        ram_waddr    = ld_ptr_q;
        ram_wdata    = bus.ld_data;
        ram_re       = 1'b0;
        bus.ld_ready = 1'b0;
        cpu_rst      = 1'b1;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    ram_we   = 1'b1;
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    // Stop at the top address instead of wrapping onto word 0.
                    if (bus.ld_last || ld_ptr_q == LAST_ADDR) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = RUN;
            RUN: begin
                cpu_rst   = 1'b0;
                ram_we    = cpu_wr_ok;
                ram_waddr = bus.addr_toRAM;
                ram_wdata = bus.data_toRAM;
                // No read on the reload edge so data_fromRAM is 0 in LOAD.
                ram_re    = !reload;
                if (cpu_wr_ok && wr_count_q != '1) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
                if (reload) begin
                    state_d    = LOAD;
                    ld_ptr_d   = '0;
                    wr_count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RAM_WR_PROTECT_EN
    localparam logic [SIZE:0] PROT_W = (SIZE + 1)'(PROT_LIMIT);

    logic prot_hit;
    logic viol_q, viol_d;

    assign prot_hit  = {1'b0, bus.addr_toRAM} < PROT_W;
    assign cpu_wr_ok = bus.wrEn && !prot_hit;

    always_comb begin
        viol_d = viol_q;
        if (state_q == RUN) begin
            if (reload) begin
                viol_d = 1'b0;
            end else if (bus.wrEn && prot_hit) begin
                viol_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            viol_q <= 1'b0;
        end else begin
            viol_q <= viol_d;
        end
    end

    assign wr_violation = viol_q;
`else
    assign cpu_wr_ok    = bus.wrEn;
    assign wr_violation = 1'b0;
`endif

    assign wr_count = wr_count_q;

    ram_array #(.SIZE(SIZE)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (bus.addr_toRAM),
        .rdata_o (bus.data_fromRAM)
    );
endmodule

// File: doc/project_ram.md
Name: project_ram

Overview:
- Responder end of the CPU memory interface: a word-addressed 16-bit RAM that serves projectCPU's addr_toRAM/wrEn/data_toRAM/data_fromRAM port.
- Adds a streaming program-loader port with valid/ready handshake.
- Holds the CPU in reset via cpu_rst until loading finishes.
- Counts CPU writes for the bench.

Parameters:
SIZE, 10, address width; DEPTH = 2**SIZE words
PROT_LIMIT, 16, first writable CPU address (used only with RAM_WR_PROTECT_EN)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous, active-high reset
addr_toRAM  input  SIZE  CPU address
data_toRAM  input  16  CPU write data
wrEn  input  1  CPU write enable
data_fromRAM  output  16  registered read data to CPU
ld_valid  input  1  loader word valid
ld_data  input  16  loader word
ld_last  input  1  marks final loader word
ld_ready  output  1  loader may transfer
reload  input  1  single-cycle request to re-enter load mode
cpu_rst  output  1  drive to CPU rst
wr_count  output  16  saturating count of accepted CPU writes
wr_violation  output  1  sticky protected-write flag (0 when feature off)

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - ld_ptr=0, data_fromRAM=0, ld_ready=0, cpu_rst=1, wr_count=0, wr_violation=0.
  - Memory contents are NOT cleared.
  - rst has priority over every other input, including mid-load and mid-run.
- FSM states: IDLE -> LOAD -> RELEASE -> RUN; RUN -> LOAD on reload.
  - IDLE: one cycle; ld_ready becomes 1 on entry to LOAD.
  - LOAD:
    - ld_ready=1, cpu_rst=1.
    - Transfer when ld_valid&&ld_ready at posedge: mem[ld_ptr]=ld_data, ld_ptr++.
    - Exit to RELEASE if the transfer has ld_last=1 or ld_ptr==DEPTH-1 (no wrap).
    - ld_valid=0 stalls indefinitely with no side effects.
  - RELEASE: ld_ready=0, cpu_rst=1 for exactly one cycle, then RUN.
  - RUN:
    - cpu_rst=0, ld_ready=0; ld_* inputs ignored.
    - reload=1 at posedge -> LOAD, with ld_ptr=0, wr_count=0, cpu_rst=1 from the next cycle.
    - A CPU write in that same cycle is still performed.
- CPU port:
  - Active only in RUN.
  - Read latency 1: data_fromRAM <= mem[addr_toRAM] every RUN cycle. This matches the CPU presenting an address in one state and sampling data in the next.
  - wrEn=1: mem[addr_toRAM] <= data_toRAM at posedge.
  - Read-during-write to the same address returns OLD data (read-first).
  - Outside RUN, data_fromRAM holds 0 and wrEn is ignored.
- wr_count: increments per accepted CPU write; saturates at 16'hFFFF (no wrap).
- Loader words beyond those loaded keep prior contents.

Optional Feature:
- Macro RAM_WR_PROTECT_EN.
- Defined:
  - CPU writes with addr_toRAM < PROT_LIMIT are suppressed and not counted.
  - Suppressed writes set wr_violation=1, which stays set until rst or reload.
  - Loader writes are never protected.
- Undefined: all CPU writes are accepted; wr_violation is tied 0; PROT_LIMIT is unused.

Decomposition:
- Package project_ram_pkg: state enum (IDLE, LOAD, RELEASE, RUN), DEPTH localparam derivation, WORD_W=16.
- Sub-module ram_array:
  - DEPTH x 16 storage, one sync read port (read-first), one write port.
  - Top muxes the write port between loader (LOAD) and CPU (RUN).

Test Plan:
- Reset then load 3 words (0x1111, 0x2222, 0x3333, ld_last on third):
  - ld_ready=1 one cycle after reset release.
  - RELEASE lasts 1 cycle.
  - cpu_rst falls in RUN.
  - Reads of addr 0,1,2 return those values 1 cycle after address.
- Loader stall: ld_valid toggles 1,0,0,1 -> exactly 2 words written; ld_ptr=2; no spurious writes.
- RUN write/read: wrEn=1, addr=5, data=0xBEEF, same-cycle read of addr 5 returns old value; next-cycle read returns 0xBEEF; wr_count=1.
- Saturation: force 65536 CPU writes -> wr_count stays 0xFFFF.
- Mid-run reload with concurrent write to addr 7 (0x00AA):
  - Write lands.
  - cpu_rst=1 next cycle; wr_count=0; ld_ptr=0; data_fromRAM=0.
- RAM_WR_PROTECT_EN, PROT_LIMIT=16: write 0x1234 to addr 3 -> mem[3] unchanged, wr_violation=1, wr_count unchanged; rst clears flag.
